// File: rtl/bcd_count_pkg.sv
// Shared types and constants for the four-decade BCD stopwatch.
// Holds the digit type, decade limits and prescaler width.
package bcd_count_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX    = 4'd9;
  localparam int   NDIG       = 4;
  localparam int   PRESCALE_W = 24;

  function automatic bcd_t bcd_inc(bcd_t d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic bcd_t bcd_dec(bcd_t d);
    return (d == 4'd0) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: steps on en, rolls 9->0 (or 0->9) and passes co.
// Ports: CLK, RST, clr, en, down (BCDCNT_DOWN_EN only), q, co.
module bcd_digit
  import bcd_count_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
`ifdef BCDCNT_DOWN_EN
  input  logic down,
`endif
  output bcd_t q,
  output logic co
);

  bcd_t nxt;

`ifdef BCDCNT_DOWN_EN
  assign co  = en & (down ? (q == 4'd0)
                          : (q == BCD_MAX));
  assign nxt = down ? bcd_dec(q) : bcd_inc(q);
`else
  assign co  = en & (q == BCD_MAX);
  assign nxt = bcd_inc(q);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bcd_count4.sv
// Four-decade BCD stopwatch: START toggles run, CLEAR zeroes, ticks per PRESCALE.
// Ports: CLK, RST, START, CLEAR, DOWN (BCDCNT_DOWN_EN), DIG0..3, RUN, CARRY.
module bcd_count4
  import bcd_count_pkg::*;
#(
  parameter int PRESCALE = 500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CLEAR,
`ifdef BCDCNT_DOWN_EN
  input  logic       DOWN,
`endif
  output logic [3:0] DIG0,
  output logic [3:0] DIG1,
  output logic [3:0] DIG2,
  output logic [3:0] DIG3,
  output logic       RUN,
  output logic       CARRY
);

  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [PRESCALE_W-1:0] PMAX =
    PRESCALE_W'(PRESCALE - 1);

  logic s1, s2, s3;
  logic c1, c2;
  logic start_rise;
  logic clr;
  logic [0:0] state;
  logic run;
  logic [PRESCALE_W-1:0] pre;
  logic tick;
  logic [NDIG:0] en;
  bcd_t q [NDIG];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      c1 <= 1'b0;
      c2 <= 1'b0;
    end else begin
      s1 <= START;
      s2 <= s1;
      s3 <= s2;
      c1 <= CLEAR;
      c2 <= c1;
    end
  end

  assign start_rise = s2 & ~s3;
  assign clr        = c2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_STOP;
    end else if (start_rise) begin
      state <= (state == ST_RUN) ? ST_STOP : ST_RUN;
    end
  end

  assign run = (state == ST_RUN);

  // Holds in STOP so a resume finishes the partial period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (run) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  assign tick  = run & ~clr & (pre == PMAX);
  assign en[0] = tick;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_dig (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (clr),
      .en   (en[i]),
`ifdef BCDCNT_DOWN_EN
      .down (DOWN),
`endif
      .q    (q[i]),
      .co   (en[i+1])
    );
  end

  // Carry out of the top decade lands with the wrapped digits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CARRY <= 1'b0;
    end else begin
      CARRY <= en[NDIG];
    end
  end

  assign DIG0 = q[0];
  assign DIG1 = q[1];
  assign DIG2 = q[2];
  assign DIG3 = q[3];
  assign RUN  = run;

endmodule

// File: tb/tb_bcd_count4.sv
// Bench for bcd_count4: step table drives two instances (PRESCALE 4 and 1).
// Expected values are queued with a due cycle and checked on the falling edge.
module tb_bcd_count4;

  localparam int A_NONE  = 0;
  localparam int A_START = 1;
  localparam int A_RST   = 2;
  localparam int A_CLR1  = 3;
  localparam int A_CLR0  = 4;
  localparam int A_DN1   = 5;
  localparam int A_DN0   = 6;

  typedef struct {
    int          act;
    int          wt;
    int          u;
    logic [15:0] dig;
    logic        run;
    logic        carry;
  } step_t;

  typedef struct {
    int          due;
    int          idx;
    int          u;
    logic [15:0] dig;
    logic        run;
    logic        carry;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start4 = 1'b0;
  logic clear4 = 1'b0;
  logic start1 = 1'b0;
  logic clear1 = 1'b0;
`ifdef BCDCNT_DOWN_EN
  logic down4 = 1'b0;
  logic down1 = 1'b0;
`endif

  logic [3:0] a0, a1, a2, a3;
  logic [3:0] b0, b1, b2, b3;
  logic run4, car4, run1, car1;
  logic [15:0] q4, q1;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  step_t tbl[$];
  exp_t  sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_count4 #(.PRESCALE(4)) u4 (
    .CLK   (clk),
    .RST   (rst),
    .START (start4),
    .CLEAR (clear4),
`ifdef BCDCNT_DOWN_EN
    .DOWN  (down4),
`endif
    .DIG0  (a0),
    .DIG1  (a1),
    .DIG2  (a2),
    .DIG3  (a3),
    .RUN   (run4),
    .CARRY (car4)
  );

  bcd_count4 #(.PRESCALE(1)) u1 (
    .CLK   (clk),
    .RST   (rst),
    .START (start1),
    .CLEAR (clear1),
`ifdef BCDCNT_DOWN_EN
    .DOWN  (down1),
`endif
    .DIG0  (b0),
    .DIG1  (b1),
    .DIG2  (b2),
    .DIG3  (b3),
    .RUN   (run1),
    .CARRY (car1)
  );

  assign q4 = {a3, a2, a1, a0};
  assign q1 = {b3, b2, b1, b0};

  always @(negedge clk) begin
    exp_t e;
    logic [15:0] ad;
    logic ar, ac;
    n_cmp++;
    if (a0 > 9 || a1 > 9 || a2 > 9 || a3 > 9 ||
        b0 > 9 || b1 > 9 || b2 > 9 || b3 > 9) begin
      n_bad++;
      $display("FAIL digit_range cyc=%0d got u4=%h u1=%h want all digits <= 9",
               cyc, q4, q1);
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.u == 0) begin
        ad = q4; ar = run4; ac = car4;
      end else begin
        ad = q1; ar = run1; ac = car1;
      end
      if (e.due != cyc) begin
        n_bad++;
        $display("FAIL step%0d late: checked at cyc %0d, required %0d",
                 e.idx, cyc, e.due);
      end else if (ad !== e.dig || ar !== e.run || ac !== e.carry) begin
        n_bad++;
        $display("FAIL step%0d u%0d: got dig=%h run=%b carry=%b, want dig=%h run=%b carry=%b",
                 e.idx, (e.u == 0) ? 4 : 1, ad, ar, ac, e.dig, e.run, e.carry);
      end
    end
  end

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_step(input int i);
    step_t st;
    int ac;
    st = tbl[i];
    ac = (st.act == A_START) ? 1 : (st.act == A_RST) ? 3 : 0;
    sb.push_back('{cyc + ac + st.wt, i, st.u, st.dig, st.run, st.carry});
    case (st.act)
      A_START: begin
        if (st.u == 0) start4 = 1'b1;
        else start1 = 1'b1;
        waitn(1);
        start4 = 1'b0;
        start1 = 1'b0;
      end
      A_RST: begin
        rst = 1'b1;
        waitn(3);
        rst = 1'b0;
      end
      A_CLR1: begin
        if (st.u == 0) clear4 = 1'b1;
        else clear1 = 1'b1;
      end
      A_CLR0: begin
        clear4 = 1'b0;
        clear1 = 1'b0;
      end
`ifdef BCDCNT_DOWN_EN
      A_DN1: begin
        if (st.u == 0) down4 = 1'b1;
        else down1 = 1'b1;
      end
      A_DN0: begin
        down4 = 1'b0;
        down1 = 1'b0;
      end
`endif
      default: ;
    endcase
    waitn(st.wt);
  endtask

  initial begin
    tbl = '{
      // reset and idle
      '{A_RST,   0,     0, 16'h0000, 1'b0, 1'b0},
      '{A_NONE,  50,    0, 16'h0000, 1'b0, 1'b0},
      // start latency and step timing (PRESCALE=4)
      '{A_START, 1,     0, 16'h0000, 1'b0, 1'b0},
      '{A_NONE,  1,     0, 16'h0000, 1'b1, 1'b0},
      '{A_NONE,  3,     0, 16'h0000, 1'b1, 1'b0},
      '{A_NONE,  1,     0, 16'h0001, 1'b1, 1'b0},
      '{A_NONE,  43,    0, 16'h0011, 1'b1, 1'b0},
      '{A_NONE,  1,     0, 16'h0012, 1'b1, 1'b0},
      // start/stop toggle with partial period resume
      '{A_RST,   0,     0, 16'h0000, 1'b0, 1'b0},
      '{A_START, 9,     0, 16'h0001, 1'b1, 1'b0},
      '{A_START, 1,     0, 16'h0002, 1'b1, 1'b0},
      '{A_NONE,  1,     0, 16'h0002, 1'b0, 1'b0},
      '{A_NONE,  40,    0, 16'h0002, 1'b0, 1'b0},
      '{A_START, 1,     0, 16'h0002, 1'b0, 1'b0},
      '{A_NONE,  1,     0, 16'h0002, 1'b1, 1'b0},
      '{A_NONE,  1,     0, 16'h0002, 1'b1, 1'b0},
      '{A_NONE,  1,     0, 16'h0003, 1'b1, 1'b0},
      // clear colliding with the tick at 0457
      '{A_RST,   0,     0, 16'h0000, 1'b0, 1'b0},
      '{A_START, 1831,  0, 16'h0457, 1'b1, 1'b0},
      '{A_CLR1,  2,     0, 16'h0457, 1'b1, 1'b0},
      '{A_NONE,  1,     0, 16'h0000, 1'b1, 1'b0},
      '{A_NONE,  3,     0, 16'h0000, 1'b1, 1'b0},
      '{A_CLR0,  5,     0, 16'h0000, 1'b1, 1'b0},
      '{A_NONE,  1,     0, 16'h0001, 1'b1, 1'b0},
      // wrap with PRESCALE=1, then reset mid-count
      '{A_RST,   0,     1, 16'h0000, 1'b0, 1'b0},
      '{A_START, 10001, 1, 16'h9999, 1'b1, 1'b0},
      '{A_NONE,  1,     1, 16'h0000, 1'b1, 1'b1},
      '{A_NONE,  1,     1, 16'h0001, 1'b1, 1'b0},
      '{A_NONE,  5,     1, 16'h0006, 1'b1, 1'b0},
      '{A_RST,   0,     1, 16'h0000, 1'b0, 1'b0},
      '{A_NONE,  4,     1, 16'h0000, 1'b0, 1'b0}
    };
`ifdef BCDCNT_DOWN_EN
    tbl.push_back('{A_RST,   0,    1, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{A_DN1,   1,    1, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{A_START, 1,    1, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{A_NONE,  1,    1, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{A_NONE,  1,    1, 16'h9999, 1'b1, 1'b1});
    tbl.push_back('{A_NONE,  1,    1, 16'h9998, 1'b1, 1'b0});
    tbl.push_back('{A_RST,   0,    1, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{A_DN0,   1,    1, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{A_START, 1002, 1, 16'h1000, 1'b1, 1'b0});
    tbl.push_back('{A_DN1,   1,    1, 16'h0999, 1'b1, 1'b0});
    tbl.push_back('{A_NONE,  1,    1, 16'h0998, 1'b1, 1'b0});
`endif
    rst = 1'b1;
    waitn(1);
    foreach (tbl[i]) run_step(i);
    waitn(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
